// File: rtl/dmem_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : dmem_arbiter
// Purpose  : Shares data memory between CPU (priority) and DMA (starve-guarded)
// Revision : 1.0 - initial release
// ==========================================================================
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_stall_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_gnt_o,
   output logic              dma_rvalid_o,
   output logic [DATA_W-1:0] dma_rdata_o,
   output logic              mem_w_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_w_data_o,
   input  logic [DATA_W-1:0] mem_r_data_i
);

   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

   logic [3:0]        starve_cnt_q;
   logic [3:0]        starve_cnt_d;
   logic              cpu_rvalid_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic              dma_rvalid_q;
   logic [DATA_W-1:0] dma_rdata_q;
   logic              w_force;
   logic              w_cpu_gnt;
   logic              w_dma_gnt;

   // Grants are gated by rst so nothing reaches memory while in reset.
   always_comb begin
      w_force   = (starve_cnt_q == C_STARVE_MAX);
      w_dma_gnt = ~rst & dma_req_i & (~cpu_req_i | w_force);
      w_cpu_gnt = ~rst & cpu_req_i & ~w_dma_gnt;
   end

   always_comb begin
      mem_addr_o   = '0;
      mem_w_data_o = '0;
      mem_w_en_o   = 1'b0;
      if (w_cpu_gnt) begin
         mem_addr_o   = cpu_addr_i;
         mem_w_data_o = cpu_wdata_i;
         mem_w_en_o   = cpu_we_i;
      end else if (w_dma_gnt) begin
         mem_addr_o   = dma_addr_i;
         mem_w_data_o = dma_wdata_i;
         mem_w_en_o   = dma_we_i;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (w_dma_gnt || !dma_req_i) begin
         starve_cnt_d = 4'd0;
      end else if (starve_cnt_q < C_STARVE_MAX) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= 4'd0;
         cpu_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rvalid_q <= 1'b0;
         dma_rdata_q  <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         cpu_rvalid_q <= w_cpu_gnt & ~cpu_we_i;
         dma_rvalid_q <= w_dma_gnt & ~dma_we_i;
         if (w_cpu_gnt && !cpu_we_i) begin
            cpu_rdata_q <= mem_r_data_i;
         end
         if (w_dma_gnt && !dma_we_i) begin
            dma_rdata_q <= mem_r_data_i;
         end
      end
   end

   assign cpu_gnt_o    = w_cpu_gnt;
   assign dma_gnt_o    = w_dma_gnt;
   assign cpu_stall_o  = cpu_req_i & ~w_cpu_gnt;
   assign cpu_rvalid_o = cpu_rvalid_q;
   assign cpu_rdata_o  = cpu_rdata_q;
   assign dma_rvalid_o = dma_rvalid_q;
   assign dma_rdata_o  = dma_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter against a behavioural model
// Revision : 1.0 - initial release
// ==========================================================================
module tb_dmem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              load;
   logic              cpu_req, cpu_we, dma_req, dma_we;
   logic [ADDR_W-1:0] cpu_addr, dma_addr;
   logic [DATA_W-1:0] cpu_wdata, dma_wdata;
   logic              cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_w_en;
   logic [DATA_W-1:0] cpu_rdata, dma_rdata, mem_w_data, mem_r_data;
   logic [ADDR_W-1:0] mem_addr;

   logic [DATA_W-1:0] bmem [64];
   logic [DATA_W-1:0] rmem [64];

   int checks   = 0;
   int failures = 0;

   // reference model state
   int                starve;
   bit                exp_cpu_rv, exp_dma_rv;
   logic [DATA_W-1:0] exp_cpu_rd, exp_dma_rd;
   bit                cg, dg, ocg, odg;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
      .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
      .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata),
      .mem_w_en_o(mem_w_en), .mem_addr_o(mem_addr), .mem_w_data_o(mem_w_data),
      .mem_r_data_i(mem_r_data)
   );

   function automatic logic [DATA_W-1:0] pre(int i);
      return 32'hA500_0000 | (i * 32'h0001_0203);
   endfunction

   // Bench-side data memory: combinational read, write on the clock edge.
   assign mem_r_data = bmem[mem_addr[5:0]];
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 64; i++) bmem[i] <= pre(i);
      end else if (mem_w_en) begin
         bmem[mem_addr[5:0]] <= mem_w_data;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      starve     = 0;
      exp_cpu_rv = 0;
      exp_dma_rv = 0;
      exp_cpu_rd = '0;
      exp_dma_rd = '0;
   endtask

   // One clock cycle: inputs are already applied at the preceding negedge.
   // DMA wins when the CPU is idle or DMA has already been refused STARVE_MAX
   // times in a row; the CPU wins any other request.
   task automatic cycle(output bit e_cg, output bit e_dg, output bit o_cg, output bit o_dg);
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      bit                ew;
      #1;
      e_dg = dma_req && (!cpu_req || starve == STARVE_MAX);
      e_cg = cpu_req && !e_dg;
      ea   = e_cg ? cpu_addr  : (e_dg ? dma_addr  : '0);
      ed   = e_cg ? cpu_wdata : (e_dg ? dma_wdata : '0);
      ew   = (e_cg && cpu_we) || (e_dg && dma_we);
      o_cg = cpu_gnt;
      o_dg = dma_gnt;
      chk("cpu_gnt",    cpu_gnt,    e_cg);
      chk("dma_gnt",    dma_gnt,    e_dg);
      chk("cpu_stall",  cpu_stall,  cpu_req && !e_cg);
      chk("mem_w_en",   mem_w_en,   ew);
      chk("mem_addr",   mem_addr,   ea);
      chk("mem_w_data", mem_w_data, ed);
      @(posedge clk);
      exp_cpu_rv = e_cg && !cpu_we;
      exp_dma_rv = e_dg && !dma_we;
      if (exp_cpu_rv) exp_cpu_rd = rmem[cpu_addr[5:0]];
      if (exp_dma_rv) exp_dma_rd = rmem[dma_addr[5:0]];
      if (ew) rmem[ea[5:0]] = ed;
      if (e_dg || !dma_req) starve = 0;
      else if (starve < STARVE_MAX) starve++;
      @(negedge clk);
      chk("cpu_rvalid", cpu_rvalid, exp_cpu_rv);
      chk("cpu_rdata",  cpu_rdata,  exp_cpu_rd);
      chk("dma_rvalid", dma_rvalid, exp_dma_rv);
      chk("dma_rdata",  dma_rdata,  exp_dma_rd);
   endtask

   task automatic set_cpu(input bit req, input bit we, input int a, input logic [DATA_W-1:0] d);
      cpu_req = req; cpu_we = we; cpu_addr = ADDR_W'(a); cpu_wdata = d;
   endtask

   task automatic set_dma(input bit req, input bit we, input int a, input logic [DATA_W-1:0] d);
      dma_req = req; dma_we = we; dma_addr = ADDR_W'(a); dma_wdata = d;
   endtask

   initial begin
      rst  = 1'b1;
      load = 1'b1;
      set_cpu(1, 1, 3, 32'h1111_1111);
      set_dma(1, 1, 4, 32'h2222_2222);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_cpu_gnt",    cpu_gnt,    1'b0);
      chk("rst_dma_gnt",    dma_gnt,    1'b0);
      chk("rst_mem_w_en",   mem_w_en,   1'b0);
      chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk("rst_dma_rvalid", dma_rvalid, 1'b0);
      chk("rst_cpu_rdata",  cpu_rdata,  32'h0);
      chk("rst_dma_rdata",  dma_rdata,  32'h0);
      @(negedge clk);
      rst  = 1'b0;
      load = 1'b0;
      for (int i = 0; i < 64; i++) rmem[i] = pre(i);
      model_reset();
      set_cpu(0, 0, 0, '0);
      set_dma(0, 0, 0, '0);
      cycle(cg, dg, ocg, odg);

      // CPU write then read back
      set_cpu(1, 1, 32'h10, 32'hDEAD_BEEF);
      cycle(cg, dg, ocg, odg);
      set_cpu(1, 0, 32'h10, '0);
      cycle(cg, dg, ocg, odg);
      chk("t1_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      set_cpu(0, 0, 0, '0);

      // DMA alone write then read back
      set_dma(1, 1, 32'h20, 32'h1234);
      cycle(cg, dg, ocg, odg);
      chk("t2_wr_dgnt", odg, 1'b1);
      set_dma(1, 0, 32'h20, '0);
      cycle(cg, dg, ocg, odg);
      chk("t2_rd_dgnt", odg, 1'b1);
      chk("t2_dma_rdata", dma_rdata, 32'h1234);
      chk("t2_cpu_rvalid", cpu_rvalid, 1'b0);

      // Full contention: DMA wins every fifth cycle
      set_cpu(1, 0, 5, '0);
      set_dma(1, 0, 6, '0);
      for (int k = 1; k <= 20; k++) begin
         cycle(cg, dg, ocg, odg);
         chk("t3_dma_gnt", odg, (k % 5) == 0);
         chk("t3_cpu_gnt", ocg, (k % 5) != 0);
      end

      // Dropped DMA request clears starvation history
      for (int k = 1; k <= 9; k++) begin
         dma_req = (k != 4);
         cycle(cg, dg, ocg, odg);
         chk("t4_dma_gnt", odg, k == 9);
      end
      set_cpu(0, 0, 0, '0);
      set_dma(0, 0, 0, '0);

      // Reset pulsed while a CPU read is granted
      set_cpu(1, 0, 7, '0);
      cycle(cg, dg, ocg, odg);
      set_cpu(1, 0, 9, '0);
      #1;
      chk("t5_pre_gnt", cpu_gnt, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_cpu_gnt", cpu_gnt,    1'b0);
      chk("t5_rst_dma_gnt", dma_gnt,    1'b0);
      chk("t5_rst_w_en",    mem_w_en,   1'b0);
      chk("t5_rst_rvalid",  cpu_rvalid, 1'b0);
      chk("t5_rst_rdata",   cpu_rdata,  32'h0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      set_cpu(0, 0, 0, '0);
      chk("t5_post_rvalid", cpu_rvalid, 1'b0);
      chk("t5_post_rdata",  cpu_rdata,  32'h0);
      cycle(cg, dg, ocg, odg);

      // Alternating uncontended reads of preloaded words
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            set_cpu(1, 0, 40 + k, '0);
            set_dma(0, 0, 0, '0);
         end else begin
            set_cpu(0, 0, 0, '0);
            set_dma(1, 0, 40 + k, '0);
         end
         cycle(cg, dg, ocg, odg);
         if (k % 2 == 0) chk("t6_cpu_data", cpu_rdata, pre(40 + k));
         else            chk("t6_dma_data", dma_rdata, pre(40 + k));
      end

      // Randomised traffic; each requester holds its request until granted
      set_cpu(0, 0, 0, '0);
      set_dma(0, 0, 0, '0);
      cg = 0;
      dg = 0;
      for (int n = 0; n < 400; n++) begin
         if (!cpu_req || cg)
            set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 63), $urandom);
         if (!dma_req || dg)
            set_dma($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 63), $urandom);
         cycle(cg, dg, ocg, odg);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
